// File: rtl/sdram_read_arbiter.sv
// sdram_read_arbiter
// Shares the HPS f2h_sdram0 Avalon-MM burst-read port between two requesters:
// port 0 = HDMI framebuffer fetch, port 1 = vector-analyzer sample fetch.
// One command is issued at a time. A tag FIFO of {owner, burstcount} tracks the
// bursts in flight, and returning beats are steered to the owner of each burst.
// Optional build macro: VIDEO_PRIORITY_EN. When it is defined, port 0 has fixed
// priority. When it is not defined, the ports are served round-robin.
module sdram_read_arbiter #(
    parameter int ADDR_W          = 29,
    parameter int BURST_W         = 8,
    parameter int DATA_W          = 64,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               req0_valid,
    input  logic [ADDR_W-1:0]  req0_address,
    input  logic [BURST_W-1:0] req0_burstcount,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [ADDR_W-1:0]  req1_address,
    input  logic [BURST_W-1:0] req1_burstcount,
    output logic               req1_ready,
    output logic [DATA_W-1:0]  rd0_data,
    output logic               rd0_valid,
    output logic               rd0_last,
    output logic [DATA_W-1:0]  rd1_data,
    output logic               rd1_valid,
    output logic               rd1_last,
    output logic [ADDR_W-1:0]  avm_address,
    output logic [BURST_W-1:0] avm_burstcount,
    output logic               avm_read,
    input  logic               avm_waitrequest,
    input  logic [DATA_W-1:0]  avm_readdata,
    input  logic               avm_readdatavalid,
    output logic               busy,
    output logic               err
);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]   FIFO_FULL_CNT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0]   CNT_ONE       = CNT_W'(1);
    localparam logic [PTR_W-1:0]   PTR_ONE       = PTR_W'(1);
    localparam logic [BURST_W-1:0] BC_ONE        = BURST_W'(1);
    localparam logic [BURST_W-1:0] BC_ZERO       = BURST_W'(0);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ISSUE = 1'b1} state_t;

    state_t             state_r;
    logic               cmd_owner_r;
    logic [ADDR_W-1:0]  avm_address_r;
    logic [BURST_W-1:0] avm_burstcount_r;
    logic               avm_read_r;
    logic               req0_ready_r;
    logic               req1_ready_r;
    logic               busy_r;
    logic               err_r;
    logic [DATA_W-1:0]  rd0_data_r;
    logic [DATA_W-1:0]  rd1_data_r;
    logic               rd0_valid_r;
    logic               rd1_valid_r;
    logic               rd0_last_r;
    logic               rd1_last_r;
    logic               tag_owner_r [MAX_OUTSTANDING];
    logic [BURST_W-1:0] tag_bc_r    [MAX_OUTSTANDING];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   fifo_cnt_r;
    logic [BURST_W-1:0] beat_cnt_r;
`ifndef VIDEO_PRIORITY_EN
    logic               rr_r;
`endif

    logic               v0_s;
    logic               v1_s;
    logic               grant_s;
    logic               take_s;
    logic [ADDR_W-1:0]  grant_addr_s;
    logic [BURST_W-1:0] grant_bc_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic               push_s;
    logic               pop_s;
    logic               beat_s;
    logic               head_owner_s;
    logic [BURST_W-1:0] head_bc_s;
    logic               issue_next_s;
    logic [CNT_W-1:0]   fifo_cnt_next_s;

    // Decode of the current cycle: arbitration winner, FIFO status, push/pop and beat steering.
    always_comb begin
        // A port whose ready pulse is showing is still holding its old request; ignore it.
        v0_s         = req0_valid & ~req0_ready_r;
        v1_s         = req1_valid & ~req1_ready_r;
        fifo_full_s  = (fifo_cnt_r == FIFO_FULL_CNT);
        fifo_empty_s = (fifo_cnt_r == {CNT_W{1'b0}});
`ifdef VIDEO_PRIORITY_EN
        grant_s = ~v0_s;
`else
        if (v0_s && v1_s) begin
            grant_s = rr_r;
        end else begin
            grant_s = ~v0_s;
        end
`endif
        take_s       = (state_r == ST_IDLE) && !fifo_full_s && (v0_s || v1_s);
        grant_addr_s = grant_s ? req1_address : req0_address;
        grant_bc_s   = grant_s ? req1_burstcount : req0_burstcount;
        push_s       = (state_r == ST_ISSUE) && !avm_waitrequest;
        head_owner_s = tag_owner_r[rd_ptr_r];
        head_bc_s    = tag_bc_r[rd_ptr_r];
        beat_s       = avm_readdatavalid && !fifo_empty_s;
        pop_s        = beat_s && (beat_cnt_r == (head_bc_s - BC_ONE));
        issue_next_s = (take_s && (grant_bc_s != BC_ZERO)) ||
                       ((state_r == ST_ISSUE) && avm_waitrequest);
        case ({push_s, pop_s})
            2'b10:   fifo_cnt_next_s = fifo_cnt_r + CNT_ONE;
            2'b01:   fifo_cnt_next_s = fifo_cnt_r - CNT_ONE;
            default: fifo_cnt_next_s = fifo_cnt_r;
        endcase
    end

    // Command FSM: arbitrate in IDLE, then hold the Avalon command in ISSUE until it is accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r          <= ST_IDLE;
            cmd_owner_r      <= 1'b0;
            avm_address_r    <= {ADDR_W{1'b0}};
            avm_burstcount_r <= {BURST_W{1'b0}};
            avm_read_r       <= 1'b0;
            req0_ready_r     <= 1'b0;
            req1_ready_r     <= 1'b0;
            busy_r           <= 1'b0;
`ifndef VIDEO_PRIORITY_EN
            rr_r             <= 1'b0;
`endif
        end else begin
            req0_ready_r <= 1'b0;
            req1_ready_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (take_s) begin
                        req0_ready_r <= ~grant_s;
                        req1_ready_r <= grant_s;
`ifndef VIDEO_PRIORITY_EN
                        rr_r         <= ~grant_s;
`endif
                        // A zero-length burst is acknowledged and dropped without any bus cycle.
                        if (grant_bc_s != BC_ZERO) begin
                            cmd_owner_r      <= grant_s;
                            avm_address_r    <= grant_addr_s;
                            avm_burstcount_r <= grant_bc_s;
                            avm_read_r       <= 1'b1;
                            state_r          <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (!avm_waitrequest) begin
                        avm_read_r <= 1'b0;
                        state_r    <= ST_IDLE;
                    end
                end
                default: begin
                    avm_read_r <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
            busy_r <= issue_next_s || (fifo_cnt_next_s != {CNT_W{1'b0}});
        end
    end

    // Tag FIFO: an accepted command pushes its {owner, burstcount}; the final beat of the head burst pops it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                tag_owner_r[i] <= 1'b0;
                tag_bc_r[i]    <= {BURST_W{1'b0}};
            end
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            fifo_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                tag_owner_r[wr_ptr_r] <= cmd_owner_r;
                tag_bc_r[wr_ptr_r]    <= avm_burstcount_r;
                wr_ptr_r              <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            fifo_cnt_r <= fifo_cnt_next_s;
        end
    end

    // Response path: register each beat toward the head owner, mark its last beat, and flag stray data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd0_data_r  <= {DATA_W{1'b0}};
            rd1_data_r  <= {DATA_W{1'b0}};
            rd0_valid_r <= 1'b0;
            rd1_valid_r <= 1'b0;
            rd0_last_r  <= 1'b0;
            rd1_last_r  <= 1'b0;
            beat_cnt_r  <= {BURST_W{1'b0}};
            err_r       <= 1'b0;
        end else begin
            rd0_valid_r <= 1'b0;
            rd1_valid_r <= 1'b0;
            rd0_last_r  <= 1'b0;
            rd1_last_r  <= 1'b0;
            if (beat_s) begin
                if (head_owner_s) begin
                    rd1_data_r  <= avm_readdata;
                    rd1_valid_r <= 1'b1;
                    rd1_last_r  <= pop_s;
                end else begin
                    rd0_data_r  <= avm_readdata;
                    rd0_valid_r <= 1'b1;
                    rd0_last_r  <= pop_s;
                end
                if (pop_s) begin
                    beat_cnt_r <= {BURST_W{1'b0}};
                end else begin
                    beat_cnt_r <= beat_cnt_r + BC_ONE;
                end
            end else if (avm_readdatavalid) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    assign req0_ready     = req0_ready_r;
    assign req1_ready     = req1_ready_r;
    assign avm_address    = avm_address_r;
    assign avm_burstcount = avm_burstcount_r;
    assign avm_read       = avm_read_r;
    assign rd0_data       = rd0_data_r;
    assign rd0_valid      = rd0_valid_r;
    assign rd0_last       = rd0_last_r;
    assign rd1_data       = rd1_data_r;
    assign rd1_valid      = rd1_valid_r;
    assign rd1_last       = rd1_last_r;
    assign busy           = busy_r;
    assign err            = err_r;

endmodule

// File: tb/tb_sdram_read_arbiter.sv
// Testbench for sdram_read_arbiter. Random requests, waitrequest and beat data are
// driven. The expected results come from a queue-level model: grants are recorded in
// order, each nonzero grant owns the next burstcount beats, and the bus commands
// must match those grants in the same order.
module tb_sdram_read_arbiter;
    localparam int AW = 29;
    localparam int BW = 8;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic reset_n;
    logic req0_valid, req1_valid, req0_ready, req1_ready;
    logic [AW-1:0] req0_address, req1_address, avm_address;
    logic [BW-1:0] req0_burstcount, req1_burstcount, avm_burstcount;
    logic [DW-1:0] rd0_data, rd1_data, avm_readdata;
    logic rd0_valid, rd0_last, rd1_valid, rd1_last;
    logic avm_read, avm_waitrequest, avm_readdatavalid, busy, err;

    sdram_read_arbiter #(.ADDR_W(AW), .BURST_W(BW), .DATA_W(DW), .MAX_OUTSTANDING(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_address(req0_address), .req0_burstcount(req0_burstcount), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_address(req1_address), .req1_burstcount(req1_burstcount), .req1_ready(req1_ready),
        .rd0_data(rd0_data), .rd0_valid(rd0_valid), .rd0_last(rd0_last),
        .rd1_data(rd1_data), .rd1_valid(rd1_valid), .rd1_last(rd1_last),
        .avm_address(avm_address), .avm_burstcount(avm_burstcount), .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    // pending requests per port
    logic [AW-1:0] p0_addr[$], p1_addr[$];
    int p0_cnt[$], p1_cnt[$];
    // model: grants in order, accepted bus commands, beats sent, beats observed, expected beats
    int g_port[$], g_cnt[$], g_cyc[$];
    logic [AW-1:0] g_addr[$];
    int g_nz;
    logic [AW-1:0] c_addr[$];
    int c_cnt[$];
    logic [DW-1:0] sent_q[$];
    int beat_cyc[$];
    int o_port[$];
    logic [DW-1:0] o_data[$];
    bit o_last[$];
    int e_port[$];
    logic [DW-1:0] e_data[$];
    bit e_last[$];
    int owed;
    int rd_cycles;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_logs();
        p0_addr.delete(); p1_addr.delete(); p0_cnt.delete(); p1_cnt.delete();
        g_port.delete(); g_cnt.delete(); g_cyc.delete(); g_addr.delete(); g_nz = 0;
        c_addr.delete(); c_cnt.delete(); sent_q.delete(); beat_cyc.delete();
        o_port.delete(); o_data.delete(); o_last.delete();
        owed = 0; rd_cycles = 0;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_address = '0; req1_address = '0; req0_burstcount = '0; req1_burstcount = '0;
        avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
        clear_logs();
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    // Expected beat stream: each nonzero grant, in grant order, owns the next g_cnt beats sent.
    function automatic void build_expect();
        int k = 0;
        e_port.delete(); e_data.delete(); e_last.delete();
        foreach (g_port[i]) begin
            for (int j = 0; j < g_cnt[i]; j++) begin
                if (k < sent_q.size()) begin
                    e_port.push_back(g_port[i]);
                    e_data.push_back(sent_q[k]);
                    e_last.push_back(j == g_cnt[i] - 1);
                    k++;
                end
            end
        end
    endfunction

    // Drives the requesters, the bus slave and the data return, and logs what the DUT does.
    task automatic engine(input int max_cyc, input int beat_pct, input bit rand_wait, output bit done);
        done = 1'b0;
        for (int n = 0; n < max_cyc; n++) begin
            if (req0_ready) begin
                g_port.push_back(0); g_cyc.push_back(cyc);
                if (p0_addr.size() > 0) begin
                    g_addr.push_back(p0_addr.pop_front()); g_cnt.push_back(p0_cnt.pop_front());
                end else begin
                    g_addr.push_back('0); g_cnt.push_back(0);
                end
                if (g_cnt[g_cnt.size()-1] != 0) g_nz++;
            end
            if (req1_ready) begin
                g_port.push_back(1); g_cyc.push_back(cyc);
                if (p1_addr.size() > 0) begin
                    g_addr.push_back(p1_addr.pop_front()); g_cnt.push_back(p1_cnt.pop_front());
                end else begin
                    g_addr.push_back('0); g_cnt.push_back(0);
                end
                if (g_cnt[g_cnt.size()-1] != 0) g_nz++;
            end
            if (rd0_valid) begin o_port.push_back(0); o_data.push_back(rd0_data); o_last.push_back(rd0_last); end
            if (rd1_valid) begin o_port.push_back(1); o_data.push_back(rd1_data); o_last.push_back(rd1_last); end
            if (avm_read) rd_cycles++;
            if (p0_addr.size() == 0 && p1_addr.size() == 0 && g_nz == c_cnt.size() && owed == 0 && !avm_readdatavalid) begin
                done = 1'b1;
                avm_waitrequest = 1'b0;
                break;
            end
            req0_valid = (p0_addr.size() > 0);
            if (req0_valid) begin req0_address = p0_addr[0]; req0_burstcount = BW'(p0_cnt[0]); end
            req1_valid = (p1_addr.size() > 0);
            if (req1_valid) begin req1_address = p1_addr[0]; req1_burstcount = BW'(p1_cnt[0]); end
            avm_waitrequest = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
            if (owed > 0 && $urandom_range(0, 99) < beat_pct) begin
                avm_readdatavalid = 1'b1;
                avm_readdata = {$urandom, $urandom};
                sent_q.push_back(avm_readdata);
                beat_cyc.push_back(cyc);
                owed--;
            end else begin
                avm_readdatavalid = 1'b0;
            end
            if (avm_read && !avm_waitrequest) begin
                c_addr.push_back(avm_address);
                c_cnt.push_back(int'(avm_burstcount));
                owed += int'(avm_burstcount);
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #3;
        n_checks++;
        if ({req0_ready, req1_ready, rd0_valid, rd0_last, rd1_valid, rd1_last, avm_read, busy, err, avm_address, avm_burstcount, rd0_data, rd1_data} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: some output nonzero during reset, avm_read=%0b busy=%0b err=%0b, required all 0", avm_read, busy, err);
        end
        apply_reset();
        tick();
        n_checks++;
        if ({req0_ready, req1_ready, rd0_valid, rd1_valid, avm_read, busy, err} !== 7'b0) begin
            n_fail++; $display("FAIL reset_idle: outputs %b after release, required 0000000", {req0_ready, req1_ready, rd0_valid, rd1_valid, avm_read, busy, err});
        end
    endtask

    task automatic test_single();
        bit done;
        apply_reset();
        p0_addr.push_back(AW'(32'h100)); p0_cnt.push_back(4);
        engine(200, 60, 1'b0, done);
        build_expect();
        n_checks++;
        if (done !== 1'b1 || g_port.size() != 1 || rd_cycles != 1) begin
            n_fail++; $display("FAIL single_cmd: done=%0b grants=%0d avm_read_cycles=%0d, required 1 1 1", done, g_port.size(), rd_cycles);
        end
        n_checks++;
        if (c_addr.size() != 1 || c_addr[0] !== AW'(32'h100) || c_cnt[0] != 4) begin
            n_fail++; $display("FAIL single_bus: %0d cmds first addr=%h count=%0d, required 1 cmd addr=100 count=4", c_addr.size(), c_addr[0], c_cnt[0]);
        end
        n_checks++;
        if (o_port.size() != 4 || e_port.size() != 4) begin
            n_fail++; $display("FAIL single_beats: %0d beats seen, required 4", o_port.size());
        end
        foreach (e_port[i]) if (i < o_port.size()) begin
            n_checks++;
            if ({o_port[i], o_data[i], o_last[i]} !== {e_port[i], e_data[i], e_last[i]}) begin
                n_fail++; $display("FAIL single_beat%0d: port=%0d data=%h last=%0b, required port=%0d data=%h last=%0b", i, o_port[i], o_data[i], o_last[i], e_port[i], e_data[i], e_last[i]);
            end
        end
        n_checks++;
        if ({busy, err} !== 2'b00) begin
            n_fail++; $display("FAIL single_idle: busy=%0b err=%0b, required 0 0", busy, err);
        end
    endtask

    task automatic test_contention();
        bit done;
        int exp_g[4];
        int k = 0;
`ifdef VIDEO_PRIORITY_EN
        exp_g = '{0, 0, 1, 1};
`else
        exp_g = '{0, 1, 0, 1};
`endif
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            p0_addr.push_back(AW'($urandom)); p0_cnt.push_back($urandom_range(1, 4));
            p1_addr.push_back(AW'($urandom)); p1_cnt.push_back($urandom_range(1, 4));
        end
        engine(500, 70, 1'b1, done);
        n_checks++;
        if (done !== 1'b1 || g_port.size() != 4) begin
            n_fail++; $display("FAIL contention_done: done=%0b grants=%0d, required 1 4", done, g_port.size());
        end
        foreach (exp_g[i]) if (i < g_port.size()) begin
            n_checks++;
            if (g_port[i] != exp_g[i]) begin
                n_fail++; $display("FAIL contention_grant%0d: port %0d, required %0d", i, g_port[i], exp_g[i]);
            end
        end
        foreach (g_port[i]) if (g_cnt[i] != 0) begin
            n_checks++;
            if (k >= c_addr.size() || c_addr[k] !== g_addr[i] || c_cnt[k] != g_cnt[i]) begin
                n_fail++; $display("FAIL contention_cmd%0d: bus command missing or different, required addr=%h count=%0d", k, g_addr[i], g_cnt[i]);
            end
            k++;
        end
        build_expect();
        n_checks++;
        if (o_port.size() != e_port.size()) begin
            n_fail++; $display("FAIL contention_beats: %0d beats seen, required %0d", o_port.size(), e_port.size());
        end
        foreach (e_port[i]) if (i < o_port.size()) begin
            n_checks++;
            if ({o_port[i], o_data[i], o_last[i]} !== {e_port[i], e_data[i], e_last[i]}) begin
                n_fail++; $display("FAIL contention_beat%0d: port=%0d last=%0b, required port=%0d last=%0b", i, o_port[i], o_last[i], e_port[i], e_last[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit done;
        bit seen = 1'b0;
        logic [AW-1:0] a = AW'($urandom);
        int c = $urandom_range(1, 6);
        apply_reset();
        req1_valid = 1'b1; req1_address = a; req1_burstcount = BW'(c);
        avm_waitrequest = 1'b1;
        for (int i = 0; i < 6 && !seen; i++) begin
            tick();
            seen = req1_ready;
        end
        req1_valid = 1'b0;
        n_checks++;
        if (seen !== 1'b1 || {avm_read, avm_address, avm_burstcount} !== {1'b1, a, BW'(c)}) begin
            n_fail++; $display("FAIL bp_start: ready=%0b read=%0b addr=%h count=%0d, required 1 1 %h %0d", seen, avm_read, avm_address, avm_burstcount, a, c);
        end
        g_port.push_back(1); g_addr.push_back(a); g_cnt.push_back(c); g_cyc.push_back(cyc); g_nz = 1;
        for (int i = 1; i < 6; i++) begin
            tick();
            n_checks++;
            if ({avm_read, avm_address, avm_burstcount} !== {1'b1, a, BW'(c)}) begin
                n_fail++; $display("FAIL bp_hold%0d: read=%0b addr=%h count=%0d, required 1 %h %0d", i, avm_read, avm_address, avm_burstcount, a, c);
            end
        end
        avm_waitrequest = 1'b0;
        c_addr.push_back(a); c_cnt.push_back(c); owed = c;
        tick();
        n_checks++;
        if ({avm_read, req1_ready} !== 2'b00) begin
            n_fail++; $display("FAIL bp_release: read=%0b ready=%0b, required 0 0", avm_read, req1_ready);
        end
        engine(200, 100, 1'b0, done);
        build_expect();
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || o_port.size() != c) begin
            n_fail++; $display("FAIL bp_single_push: done=%0b busy=%0b beats=%0d, required 1 0 %0d", done, busy, o_port.size(), c);
        end
        foreach (e_port[i]) if (i < o_port.size()) begin
            n_checks++;
            if ({o_port[i], o_data[i], o_last[i]} !== {e_port[i], e_data[i], e_last[i]}) begin
                n_fail++; $display("FAIL bp_beat%0d: port=%0d last=%0b, required port=%0d last=%0b", i, o_port[i], o_last[i], e_port[i], e_last[i]);
            end
        end
    endtask

    task automatic test_outstanding();
        bit done;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            p1_addr.push_back(AW'($urandom)); p1_cnt.push_back(2);
        end
        engine(40, 0, 1'b0, done);
        n_checks++;
        if (done !== 1'b0 || g_port.size() != 4 || busy !== 1'b1 || req1_valid !== 1'b1) begin
            n_fail++; $display("FAIL outstanding_limit: done=%0b grants=%0d busy=%0b, required 0 4 1", done, g_port.size(), busy);
        end
        engine(400, 100, 1'b0, done);
        n_checks++;
        if (done !== 1'b1 || g_port.size() != 5 || beat_cyc.size() < 2) begin
            n_fail++; $display("FAIL outstanding_drain: done=%0b grants=%0d, required 1 5", done, g_port.size());
        end else begin
            n_checks++;
            if (g_cyc[4] <= beat_cyc[1]) begin
                n_fail++; $display("FAIL outstanding_wait: 5th grant at cycle %0d, required after 2nd beat cycle %0d", g_cyc[4], beat_cyc[1]);
            end
        end
        build_expect();
        n_checks++;
        if (o_port.size() != 10 || e_port.size() != 10) begin
            n_fail++; $display("FAIL outstanding_beats: %0d beats seen, required 10", o_port.size());
        end
        foreach (e_port[i]) if (i < o_port.size()) begin
            n_checks++;
            if ({o_port[i], o_data[i], o_last[i]} !== {e_port[i], e_data[i], e_last[i]}) begin
                n_fail++; $display("FAIL outstanding_beat%0d: port=%0d last=%0b, required port=%0d last=%0b", i, o_port[i], o_last[i], e_port[i], e_last[i]);
            end
        end
    endtask

    task automatic test_interleave();
        bit done;
        apply_reset();
        p0_addr.push_back(AW'($urandom)); p0_cnt.push_back(3);
        p1_addr.push_back(AW'($urandom)); p1_cnt.push_back(1);
        engine(200, 100, 1'b0, done);
        build_expect();
        n_checks++;
        if (done !== 1'b1 || o_port.size() != 4 || e_port.size() != 4) begin
            n_fail++; $display("FAIL interleave_done: done=%0b beats=%0d, required 1 4", done, o_port.size());
        end
        foreach (e_port[i]) if (i < o_port.size()) begin
            n_checks++;
            if ({o_port[i], o_data[i], o_last[i]} !== {e_port[i], e_data[i], e_last[i]}) begin
                n_fail++; $display("FAIL interleave_beat%0d: port=%0d data=%h last=%0b, required port=%0d data=%h last=%0b", i, o_port[i], o_data[i], o_last[i], e_port[i], e_data[i], e_last[i]);
            end
        end
    endtask

    task automatic test_errors();
        bit done;
        apply_reset();
        avm_readdatavalid = 1'b1; avm_readdata = {$urandom, $urandom};
        tick();
        avm_readdatavalid = 1'b0;
        n_checks++;
        if ({rd0_valid, rd1_valid, err} !== 3'b001) begin
            n_fail++; $display("FAIL err_stray: rd0_valid=%0b rd1_valid=%0b err=%0b, required 0 0 1", rd0_valid, rd1_valid, err);
        end
        p0_addr.push_back(AW'($urandom)); p0_cnt.push_back(0);
        engine(30, 0, 1'b0, done);
        n_checks++;
        if (done !== 1'b1 || g_port.size() != 1 || rd_cycles != 0 || busy !== 1'b0 || err !== 1'b1) begin
            n_fail++; $display("FAIL err_zero_count: done=%0b grants=%0d avm_read_cycles=%0d busy=%0b err=%0b, required 1 1 0 0 1", done, g_port.size(), rd_cycles, busy, err);
        end
        apply_reset();
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++; $display("FAIL err_reset_clear: err=%0b, required 0", err);
        end
        p1_addr.push_back(AW'($urandom)); p1_cnt.push_back(4);
        engine(10, 0, 1'b0, done);
        n_checks++;
        if (c_cnt.size() != 1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL err_midburst_setup: cmds=%0d busy=%0b, required 1 1", c_cnt.size(), busy);
        end
        apply_reset();
        avm_readdatavalid = 1'b1; avm_readdata = {$urandom, $urandom};
        tick();
        avm_readdatavalid = 1'b0;
        n_checks++;
        if ({rd0_valid, rd1_valid, err} !== 3'b001) begin
            n_fail++; $display("FAIL err_after_reset_beat: rd0_valid=%0b rd1_valid=%0b err=%0b, required 0 0 1", rd0_valid, rd1_valid, err);
        end
    endtask

    task automatic test_random();
        bit done;
        int k = 0;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            p0_addr.push_back(AW'($urandom)); p0_cnt.push_back($urandom_range(0, 6));
            p1_addr.push_back(AW'($urandom)); p1_cnt.push_back($urandom_range(0, 6));
        end
        engine(3000, 50, 1'b1, done);
        n_checks++;
        if (done !== 1'b1 || g_port.size() != 12 || busy !== 1'b0 || err !== 1'b0) begin
            n_fail++; $display("FAIL random_done: done=%0b grants=%0d busy=%0b err=%0b, required 1 12 0 0", done, g_port.size(), busy, err);
        end
        n_checks++;
        if (c_cnt.size() != g_nz) begin
            n_fail++; $display("FAIL random_cmd_count: %0d bus commands, required %0d", c_cnt.size(), g_nz);
        end
        foreach (g_port[i]) if (g_cnt[i] != 0 && k < c_addr.size()) begin
            n_checks++;
            if (c_addr[k] !== g_addr[i] || c_cnt[k] != g_cnt[i]) begin
                n_fail++; $display("FAIL random_cmd%0d: addr=%h count=%0d, required addr=%h count=%0d", k, c_addr[k], c_cnt[k], g_addr[i], g_cnt[i]);
            end
            k++;
        end
        build_expect();
        n_checks++;
        if (o_port.size() != e_port.size()) begin
            n_fail++; $display("FAIL random_beats: %0d beats seen, required %0d", o_port.size(), e_port.size());
        end
        foreach (e_port[i]) if (i < o_port.size()) begin
            n_checks++;
            if ({o_port[i], o_data[i], o_last[i]} !== {e_port[i], e_data[i], e_last[i]}) begin
                n_fail++; $display("FAIL random_beat%0d: port=%0d data=%h last=%0b, required port=%0d data=%h last=%0b", i, o_port[i], o_data[i], o_last[i], e_port[i], e_data[i], e_last[i]);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_address = '0; req1_address = '0; req0_burstcount = '0; req1_burstcount = '0;
        avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
        clear_logs();
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_outstanding();
        test_interleave();
        test_errors();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
